rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
- Pipelined RV32I decode stage: takes a fetched instruction word plus its PC and produces the registered control bundle for the execute stage.
- The bundle includes the 3-bit ALU operation class, the 4-bit ALU function code, the sign-extended immediate, register addresses and datapath enables.
- Sits between fetch and execute with a valid/ready handshake on both sides, plus flush for taken branches and jumps.
- Latency is one cycle, with full-throughput back-pressure.

Parameters:
- XLEN, 32, data/immediate width.
- PC_W, 32, program counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction address
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  bundle valid to execute
- out_ready  in  1  execute accepts bundle
- out_pc  out  PC_W  registered PC
- alu_op  out  3  ALU operation class
- alu_func  out  4  {instr[30], instr[14:12]}
- imm  out  XLEN  sign-extended immediate
- rs1, rs2, rd  out  5 each  register addresses
- reg_write, mem_read, mem_write, branch, jal, jalr, alu_src_imm, lui, auipc  out  1 each  control enables
- illegal  out  1  unsupported opcode flag

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, every registered output=0, in_ready=1 after release.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational.
  - Load occurs when in_valid && in_ready && !flush; the next cycle has out_valid=1 and new fields.
  - If out_valid && out_ready && no load, out_valid→0 the next cycle; the data fields may hold their stale value.
  - While out_valid && !out_ready, all outputs hold bit-stable.
- Flush has priority over everything except reset: the next cycle gives out_valid=0 and the input that cycle is dropped (in_ready value is don't-care while flush=1).
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on load.
  - FULL→FULL on load (simultaneous drain+fill, full throughput).
  - FULL→EMPTY on drain without load, or on flush.
  - Any state→EMPTY on flush.
- alu_op encoding, decided here:
  - 000 add: LOAD, STORE, JAL, JALR, AUIPC, LUI.
  - 001 sub: BRANCH; the execute stage uses alu_func[2:0] for the compare.
  - 010 R-type: OP (0110011).
  - 110 I-type: OP-IMM (0010011) with funct3∉{1,5}; bit2 forces add and ignores instr[30].
  - OP-IMM with funct3=1 or 5 (shifts) emits 010 so instr[30] selects SRLI/SRAI; shamt sits in imm[4:0].
- alu_func = {instr[30], instr[14:12]} always, including for non-ALU opcodes.
- Immediates (bit 31 sign-extended to XLEN):
  - I = instr[31:20].
  - S = {[31:25],[11:7]}.
  - B = {[31],[7],[30:25],[11:8],0}.
  - U = {[31:12],12'b0}.
  - J = {[31],[19:12],[20],[30:21],0}.
  - R-type gives imm=0.
- alu_src_imm=1 for all formats except OP and BRANCH.
- reg_write=1 for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC.
- reg_write is forced to 0 when rd=0. The rd field is still output unchanged.
- Illegal opcode, or OP with instr[31:25] ∉ {0000000, 0100000}:
  - Loaded normally: out_valid=1, illegal=1.
  - All enables 0, alu_op=000, imm=0.
- FENCE/SYSTEM (0001111/1110011) decode as a NOP with illegal=0 and all enables 0.
- Reset asserted mid-stream drops the held bundle immediately; there is no partial state.

Test Plan:
- 0x002081B3 (ADD x3,x1,x2) loaded with out_ready=1 → next cycle: out_valid=1, alu_op=010, alu_func=0000, rs1=1, rs2=2, rd=3, reg_write=1, alu_src_imm=0, imm=0.
- 0x40335293 (SRAI x5,x6,3) → alu_op=010, alu_func=1101, imm=0x00000403, alu_src_imm=1, rd=5, reg_write=1.
- 0xFE208CE3 (BEQ x1,x2,-8) → alu_op=001, alu_func[2:0]=000, imm=0xFFFFFFF8, branch=1, reg_write=0, alu_src_imm=0.
- Back-pressure: load ADDI, hold out_ready=0 for 3 cycles with a new in_valid → in_ready=0, outputs bit-stable. Raise out_ready → the new instruction appears the next cycle, with no bubble and no loss.
- flush=1 with out_valid=1 and in_valid=1 on the same cycle → next cycle out_valid=0, and the incoming instruction never appears. Also: pulse rst_n=0 mid-cycle while FULL → out_valid=0 asynchronously, before the next edge.
- 0x00000000 → out_valid=1, illegal=1, all enables 0. Also: ADDI x0,x0,1 (0x00100013) → reg_write=0, alu_op=110.

Source files
------------

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: turns a fetched instruction word + PC into the registered control bundle for execute.
// Latency: one cycle from an accepted instruction to out_valid; full throughput (drain and refill in the same cycle).
// Backpressure: in_ready = !out_valid || out_ready; the held bundle stays bit-stable while out_ready is low; flush empties the stage.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready, in_instr,    fetch side handshake, instruction word and its address
//   in_pc
//   flush                           kills the held bundle and drops the incoming instruction
//   out_valid/out_ready, out_pc     execute side handshake and registered PC
//   alu_op, alu_func, imm           ALU class, {instr[30], funct3}, sign-extended immediate
//   rs1, rs2, rd                    raw register address fields
//   reg_write .. auipc, illegal     datapath enables and unsupported-instruction flag
module rv_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [2:0]      alu_op,
  output logic [3:0]      alu_func,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jal,
  output logic            jalr,
  output logic            alu_src_imm,
  output logic            lui,
  output logic            auipc,
  output logic            illegal
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_REG  = 3'b010;
  localparam logic [2:0] ALU_IMM  = 3'b110;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [2:0]      alu_op;
    logic [3:0]      alu_func;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            alu_src_imm;
    logic            lui;
    logic            auipc;
    logic            illegal;
  } ctl_t;

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  ctl_t            r_ctl;
  ctl_t            w_dec;
  logic            w_load;
  logic            w_in_ready;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];

  // Size casts of signed operands replicate instr[31] up to XLEN.
  assign w_imm_i = XLEN'($signed(in_instr[31:20]));
  assign w_imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign w_imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

  always_comb begin
    w_dec          = '0;
    w_dec.pc       = in_pc;
    w_dec.alu_func = {in_instr[30], w_funct3};
    w_dec.rs1      = in_instr[19:15];
    w_dec.rs2      = in_instr[24:20];
    w_dec.rd       = in_instr[11:7];
    case (w_opcode)
      OPC_OP: begin
        if (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000) begin
          w_dec.alu_op    = ALU_REG;
          w_dec.reg_write = 1'b1;
        end else begin
          w_dec.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // Shifts need instr[30] to pick SRLI/SRAI, so they take the R-type class.
        w_dec.alu_op      = (w_funct3 == 3'd1 || w_funct3 == 3'd5) ? ALU_REG : ALU_IMM;
        w_dec.imm         = w_imm_i;
        w_dec.alu_src_imm = 1'b1;
        w_dec.reg_write   = 1'b1;
      end
      OPC_LOAD: begin
        w_dec.alu_op      = ALU_ADD;
        w_dec.imm         = w_imm_i;
        w_dec.alu_src_imm = 1'b1;
        w_dec.mem_read    = 1'b1;
        w_dec.reg_write   = 1'b1;
      end
      OPC_STORE: begin
        w_dec.alu_op      = ALU_ADD;
        w_dec.imm         = w_imm_s;
        w_dec.alu_src_imm = 1'b1;
        w_dec.mem_write   = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.alu_op = ALU_SUB;
        w_dec.imm    = w_imm_b;
        w_dec.branch = 1'b1;
      end
      OPC_JAL: begin
        w_dec.alu_op      = ALU_ADD;
        w_dec.imm         = w_imm_j;
        w_dec.alu_src_imm = 1'b1;
        w_dec.jal         = 1'b1;
        w_dec.reg_write   = 1'b1;
      end
      OPC_JALR: begin
        w_dec.alu_op      = ALU_ADD;
        w_dec.imm         = w_imm_i;
        w_dec.alu_src_imm = 1'b1;
        w_dec.jalr        = 1'b1;
        w_dec.reg_write   = 1'b1;
      end
      OPC_LUI: begin
        w_dec.alu_op      = ALU_ADD;
        w_dec.imm         = w_imm_u;
        w_dec.alu_src_imm = 1'b1;
        w_dec.lui         = 1'b1;
        w_dec.reg_write   = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.alu_op      = ALU_ADD;
        w_dec.imm         = w_imm_u;
        w_dec.alu_src_imm = 1'b1;
        w_dec.auipc       = 1'b1;
        w_dec.reg_write   = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        // Treated as a NOP: nothing enabled, not flagged.
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
    // Writes to x0 are suppressed here so execute never needs to look at rd.
    if (w_dec.rd == 5'd0) begin
      w_dec.reg_write = 1'b0;
    end
  end

  assign w_in_ready = (r_state == S_EMPTY) || out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      w_load = in_valid && w_in_ready;
      if (w_load) begin
        w_state_nxt = S_FULL;
      end else if (out_ready) begin
        w_state_nxt = S_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bundle only changes on a load, which keeps it stable during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl <= '0;
    end else if (w_load) begin
      r_ctl <= w_dec;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = (r_state == S_FULL);
  assign out_pc      = r_ctl.pc;
  assign alu_op      = r_ctl.alu_op;
  assign alu_func    = r_ctl.alu_func;
  assign imm         = r_ctl.imm;
  assign rs1         = r_ctl.rs1;
  assign rs2         = r_ctl.rs2;
  assign rd          = r_ctl.rd;
  assign reg_write   = r_ctl.reg_write;
  assign mem_read    = r_ctl.mem_read;
  assign mem_write   = r_ctl.mem_write;
  assign branch      = r_ctl.branch;
  assign jal         = r_ctl.jal;
  assign jalr        = r_ctl.jalr;
  assign alu_src_imm = r_ctl.alu_src_imm;
  assign lui         = r_ctl.lui;
  assign auipc       = r_ctl.auipc;
  assign illegal     = r_ctl.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed test-plan cases plus randomized traffic against a reference model.
// The model holds at most one expected bundle and follows the handshake rules cycle by cycle.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven between edges.
module tb_rv_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [2:0]  alu_op;
  logic [3:0]  alu_func;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write, mem_read, mem_write, branch, jal, jalr, alu_src_imm, lui, auipc, illegal;

  rv_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_op(alu_op), .alu_func(alu_func), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .jal(jal), .jalr(jalr), .alu_src_imm(alu_src_imm), .lui(lui), .auipc(auipc),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enable vector order: {reg_write, mem_read, mem_write, branch, jal, jalr, alu_src_imm, lui, auipc, illegal}
  logic [9:0] dut_en;
  assign dut_en = {reg_write, mem_read, mem_write, branch, jal, jalr, alu_src_imm, lui, auipc, illegal};

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  fn;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  en;
    logic [31:0] pc;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  logic m_valid;
  exp_t m_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode written from the instruction-set rules using shifts and masks.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] sx;
    logic        known, legal, nop, wr;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    sx  = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    e.fn  = {ins[30], f3};
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.pc  = pc;
    e.op  = 3'd0;
    e.imm = 32'd0;
    e.en  = 10'd0;
    known = (opc == 7'h03) || (opc == 7'h23) || (opc == 7'h63) || (opc == 7'h6F) ||
            (opc == 7'h67) || (opc == 7'h37) || (opc == 7'h17) || (opc == 7'h33) ||
            (opc == 7'h13) || (opc == 7'h0F) || (opc == 7'h73);
    legal = known && !(opc == 7'h33 && f7 != 7'h00 && f7 != 7'h20);
    nop   = (opc == 7'h0F) || (opc == 7'h73);
    if (!legal) begin
      e.en = 10'b0000000001;
    end else if (!nop) begin
      case (opc)
        7'h63:   e.op = 3'd1;
        7'h33:   e.op = 3'd2;
        7'h13:   e.op = (f3 == 3'd1 || f3 == 3'd5) ? 3'd2 : 3'd6;
        default: e.op = 3'd0;
      endcase
      case (opc)
        7'h13, 7'h03, 7'h67: e.imm = 32'($signed(ins) >>> 20);
        7'h23: e.imm = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
        7'h63: e.imm = (sx & 32'hFFFF_F000) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        7'h6F: e.imm = (sx & 32'hFFF0_0000) | (ins & 32'h000F_F000) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        7'h37, 7'h17: e.imm = ins & 32'hFFFF_F000;
        default: e.imm = 32'd0;
      endcase
      wr = (opc != 7'h23) && (opc != 7'h63) && (ins[11:7] != 5'd0);
      e.en = {wr, opc == 7'h03, opc == 7'h23, opc == 7'h63, opc == 7'h6F, opc == 7'h67,
              !(opc == 7'h33 || opc == 7'h63), opc == 7'h37, opc == 7'h17, 1'b0};
    end
    return e;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk({tag, ".alu_op"}, 64'(alu_op), 64'(m_exp.op));
      chk({tag, ".alu_func"}, 64'(alu_func), 64'(m_exp.fn));
      chk({tag, ".imm"}, 64'(imm), 64'(m_exp.imm));
      chk({tag, ".regs"}, 64'({rs1, rs2, rd}), 64'({m_exp.rs1, m_exp.rs2, m_exp.rd}));
      chk({tag, ".en"}, 64'(dut_en), 64'(m_exp.en));
      chk({tag, ".pc"}, 64'(out_pc), 64'(m_exp.pc));
    end
  endtask

  // One clock of traffic; leaves time at posedge+1 with outputs checked.
  task automatic step(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic acc;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (!fl) chk({tag, ".in_ready"}, 64'(in_ready), 64'(!m_valid || ordy));
    acc = v && (!m_valid || ordy) && !fl;
    @(posedge clk);
    if (fl) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_exp   = ref_decode(ins, pc);
    end else if (ordy) m_valid = 1'b0;
    #1;
    check_model(tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  opcs [13];
    opcs = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33, 7'h13, 7'h0F, 7'h73, 7'h00, 7'h7F};
    ins = $urandom;
    ins[6:0] = opcs[$urandom_range(0, 12)];
    if (ins[6:0] == 7'h33 && $urandom_range(0, 3) != 0) ins[31:25] = ins[30] ? 7'h20 : 7'h00;
    if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
    if ($urandom_range(0, 4) == 0) ins[6:0] = 7'($urandom);
    return ins;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_pc     = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    m_valid   = 1'b0;
    m_exp     = ref_decode(32'h0000_0013, 32'd0);

    // Reset state.
    #12;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.fields", 64'({alu_op, alu_func, rs1, rs2, rd, dut_en}), 64'd0);
    chk("rst.imm_pc", {imm, out_pc}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD x3,x1,x2
    step("add", 1'b1, 32'h0020_81B3, 32'h0000_1000, 1'b1, 1'b0);
    chk("add.alu_op", 64'(alu_op), 64'd2);
    chk("add.alu_func", 64'(alu_func), 64'd0);
    chk("add.regs", 64'({rs1, rs2, rd}), 64'({5'd1, 5'd2, 5'd3}));
    chk("add.en", 64'(dut_en), 64'(10'b1000000000));
    chk("add.imm", 64'(imm), 64'd0);

    // SRAI x5,x6,3
    step("srai", 1'b1, 32'h4033_5293, 32'h0000_1004, 1'b1, 1'b0);
    chk("srai.alu_op", 64'(alu_op), 64'd2);
    chk("srai.alu_func", 64'(alu_func), 64'hD);
    chk("srai.imm", 64'(imm), 64'h403);
    chk("srai.en", 64'(dut_en), 64'(10'b1000001000));
    chk("srai.rd", 64'(rd), 64'd5);

    // BEQ x1,x2,-8
    step("beq", 1'b1, 32'hFE20_8CE3, 32'h0000_1008, 1'b1, 1'b0);
    chk("beq.alu_op", 64'(alu_op), 64'd1);
    chk("beq.func3", 64'(alu_func[2:0]), 64'd0);
    chk("beq.imm", 64'(imm), 64'hFFFF_FFF8);
    chk("beq.en", 64'(dut_en), 64'(10'b0001000000));

    // All-zero word is illegal but still delivered.
    step("zero", 1'b1, 32'h0000_0000, 32'h0000_100C, 1'b1, 1'b0);
    chk("zero.valid", 64'(out_valid), 64'd1);
    chk("zero.en", 64'(dut_en), 64'(10'b0000000001));
    chk("zero.alu_op_imm", 64'({alu_op, imm}), 64'd0);

    // ADDI x0,x0,1: write to x0 suppressed.
    step("addi0", 1'b1, 32'h0010_0013, 32'h0000_1010, 1'b1, 1'b0);
    chk("addi0.alu_op", 64'(alu_op), 64'd6);
    chk("addi0.en", 64'(dut_en), 64'(10'b0000001000));
    chk("addi0.imm", 64'(imm), 64'd1);
    step("drain", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Back-pressure: ADDI held for three stalled cycles, then a new instruction flows in.
    step("bp.load", 1'b1, 32'h0051_0093, 32'h0000_2000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("bp.stall", 1'b1, 32'h0041_81B3, 32'h0000_2004, 1'b0, 1'b0);
      chk("bp.pc_held", 64'(out_pc), 64'h2000);
    end
    step("bp.release", 1'b1, 32'h0041_81B3, 32'h0000_2004, 1'b1, 1'b0);
    chk("bp.new_pc", 64'(out_pc), 64'h2004);
    chk("bp.new_valid", 64'(out_valid), 64'd1);

    // Flush while full with an instruction arriving.
    step("fl.load", 1'b1, 32'h0000_0517, 32'h0000_3000, 1'b0, 1'b0);
    step("fl.flush", 1'b1, 32'h0010_0293, 32'h0000_3004, 1'b1, 1'b1);
    chk("fl.valid", 64'(out_valid), 64'd0);
    step("fl.idle", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("fl.dropped", 64'(out_valid), 64'd0);

    // Asynchronous reset while full.
    step("ar.load", 1'b1, 32'h1234_50B7, 32'h0000_4000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.valid", 64'(out_valid), 64'd0);
    chk("ar.fields", {imm, out_pc}, 64'd0);
    m_valid = 1'b0;
    #1;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step("rnd", ($urandom_range(0, 9) < 7), rand_instr(), {$urandom, 2'b00} & 32'hFFFF_FFFC,
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
